// File: rtl/can_tx_pkg.sv
// ============================================================
// can_tx_pkg : shared constants and state type for CAN header TX
// Rev 1.0
// ============================================================
`default_nettype none

package can_tx_pkg;

  localparam int HDR_LEN   = 19;
  localparam int STUFF_RUN = 5;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } txState_t;

endpackage

`default_nettype wire

// File: rtl/can_bit_stuffer.sv
// ============================================================
// can_bit_stuffer : tracks equal-bit run and picks stuff vs data bit
// Rev 1.0
// ============================================================
`default_nettype none

module can_bit_stuffer
  import can_tx_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic [2:0] load_run,
  input  logic       load_last,
  input  logic       step,
  input  logic       data_bit,
  output logic       stuff_now,
  output logic       out_bit,
  output logic [2:0] run_len,
  output logic       last_bit
);

  assign stuff_now = (run_len == 3'(STUFF_RUN));
  assign out_bit   = stuff_now ? ~last_bit : data_bit;

  // The stuff bit itself opens a new run of length one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      run_len  <= 3'd0;
      last_bit <= RECESSIVE;
    end else if (load) begin
      run_len  <= load_run;
      last_bit <= load_last;
    end else if (step) begin
      if (stuff_now) begin
        run_len  <= 3'd1;
        last_bit <= ~last_bit;
      end else begin
        run_len  <= (data_bit == last_bit) ? run_len + 3'd1 : 3'd1;
        last_bit <= data_bit;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/can_header_tx.sv
// ============================================================
// can_header_tx : serializes a CAN 2.0A base header with bit stuffing
// Rev 1.0
// ============================================================
`default_nettype none

module can_header_tx
  import can_tx_pkg::*;
#(
  parameter bit STUFF_TAIL = 1'b1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        abort,
  input  logic        bitPulse,
  input  logic [10:0] canId,
  input  logic        rtr,
  input  logic [3:0]  msgSize,
  output logic        dOut,
  output logic        busy,
  output logic        done,
  output logic        stuffActive,
  output logic [2:0]  stuffCount,
  output logic [2:0]  runLen,
  output logic        lastBit
);

  txState_t             state;
  txState_t             state_nxt;
  logic [HDR_LEN-1:0]   hdr;
  logic [4:0]           hdr_cnt;
  logic                 bus_bit;
  logic                 stuff_flag;
  logic [2:0]           stuff_cnt;
  logic                 load;
  logic                 step;
  logic                 stuff_now;
  logic                 out_bit;
  logic                 tail_needed;

  assign tail_needed = STUFF_TAIL && stuff_now;
  assign load        = !abort && (state == S_IDLE) && start;
  assign step        = !abort && bitPulse &&
                       ((state == S_SEND) || ((state == S_TAIL) && tail_needed));

  can_bit_stuffer u_stuffer (
    .clk       (clk),
    .resetN    (resetN),
    .load      (load),
    .load_run  (3'd0),
    .load_last (RECESSIVE),
    .step      (step),
    .data_bit  (hdr[HDR_LEN-1]),
    .stuff_now (stuff_now),
    .out_bit   (out_bit),
    .run_len   (runLen),
    .last_bit  (lastBit)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_SEND;
        S_SEND: if (bitPulse && !stuff_now && (hdr_cnt == 5'(HDR_LEN - 1)))
                  state_nxt = S_TAIL;
        S_TAIL: if (!tail_needed || bitPulse) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // A stuff step leaves the shift register parked on the pending data bit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hdr        <= '0;
      hdr_cnt    <= 5'd0;
      bus_bit    <= RECESSIVE;
      stuff_flag <= 1'b0;
      stuff_cnt  <= 3'd0;
    end else if (abort) begin
      bus_bit    <= RECESSIVE;
      stuff_flag <= 1'b0;
    end else if (load) begin
      hdr       <= {DOMINANT, canId, rtr, DOMINANT, DOMINANT, msgSize};
      hdr_cnt   <= 5'd0;
      stuff_cnt <= 3'd0;
    end else if (step) begin
      bus_bit    <= out_bit;
      stuff_flag <= stuff_now;
      if (stuff_now) begin
        stuff_cnt <= stuff_cnt + 3'd1;
      end else begin
        hdr     <= {hdr[HDR_LEN-2:0], 1'b0};
        hdr_cnt <= hdr_cnt + 5'd1;
      end
    end else if (state == S_DONE) begin
      stuff_flag <= 1'b0;
    end
  end

  assign dOut        = bus_bit;
  assign stuffActive = stuff_flag;
  assign stuffCount  = stuff_cnt;

endmodule

`default_nettype wire

// File: tb/tb_can_header_tx.sv
// ============================================================
// tb_can_header_tx : self-checking bench, STUFF_TAIL=0 and =1 side by side
// Rev 1.0
// ============================================================
`default_nettype none

module tb_can_header_tx;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        abort;
  logic        bitPulse;
  logic [10:0] canId;
  logic        rtr;
  logic [3:0]  msgSize;

  // index 0: STUFF_TAIL=0, index 1: STUFF_TAIL=1
  logic [1:0]  dout_v, busy_v, done_v, sact_v, last_v;
  logic [2:0]  scnt_v [2];
  logic [2:0]  run_v  [2];

  can_header_tx #(.STUFF_TAIL(1'b0)) dut_t0 (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .bitPulse(bitPulse),
    .canId(canId), .rtr(rtr), .msgSize(msgSize),
    .dOut(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .stuffActive(sact_v[0]),
    .stuffCount(scnt_v[0]), .runLen(run_v[0]), .lastBit(last_v[0])
  );

  can_header_tx #(.STUFF_TAIL(1'b1)) dut_t1 (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .bitPulse(bitPulse),
    .canId(canId), .rtr(rtr), .msgSize(msgSize),
    .dOut(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .stuffActive(sact_v[1]),
    .stuffCount(scnt_v[1]), .runLen(run_v[1]), .lastBit(last_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: expected bus stream built from the stuffing rule on the bit stream
  bit mbit [2][40];
  bit mstf [2][40];
  int mlen [2];
  int mscnt[2];
  int mrun [2];
  int mlast[2];

  task automatic model(input logic [10:0] id, input logic r, input logic [3:0] d);
    logic [18:0] f;
    f = {1'b0, id, r, 1'b0, 1'b0, d};
    for (int t = 0; t < 2; t++) begin
      int n, cnt, sc;
      bit prev;
      n = 0; cnt = 0; sc = 0; prev = 1'b1;
      for (int i = 18; i >= 0; i--) begin
        if (cnt == 5) begin
          mbit[t][n] = !prev; mstf[t][n] = 1'b1; n++;
          prev = !prev; cnt = 1; sc++;
        end
        mbit[t][n] = f[i]; mstf[t][n] = 1'b0; n++;
        cnt  = (f[i] == prev) ? cnt + 1 : 1;
        prev = f[i];
      end
      if (t == 1 && cnt == 5) begin
        mbit[t][n] = !prev; mstf[t][n] = 1'b1; n++;
        prev = !prev; cnt = 1; sc++;
      end
      mlen[t] = n; mscnt[t] = sc; mrun[t] = cnt; mlast[t] = int'(prev);
    end
  endtask

  int seen [2];
  int extra[2];
  int cap_s[2];
  int cap_r[2];
  int cap_l[2];

  task automatic look_done(input int n);
    for (int t = 0; t < 2; t++) begin
      if (done_v[t]) begin
        if (seen[t] < 0) begin
          seen[t]  = n;
          cap_s[t] = int'(scnt_v[t]);
          cap_r[t] = int'(run_v[t]);
          cap_l[t] = int'(last_v[t]);
        end else begin
          extra[t]++;
        end
      end
    end
  endtask

  task automatic pulse_gap();
    bitPulse = 1'b1;
    @(negedge clk);
    bitPulse = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [10:0] id, input logic r, input logic [3:0] d,
                           input bit coinc, input bit glitch);
    int p;
    model(id, r, d);
    seen  = '{-1, -1};
    extra = '{0, 0};
    canId = id; rtr = r; msgSize = d;
    start = 1'b1; bitPulse = coinc;
    @(negedge clk);
    start = 1'b0; bitPulse = 1'b0;
    chk("start_busy", int'(busy_v[1]), 1);
    chk("start_stuffcount", int'(scnt_v[1]), 0);
    if (coinc) chk("coincident_pulse_dout_hold", int'(dout_v[1]), 1);
    p = 0;
    while (p < 40 && (seen[0] < 0 || seen[1] < 0)) begin
      if (glitch && p == 3) begin
        canId = ~id; rtr = ~r; msgSize = ~d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_while_busy", int'(busy_v[1]), 1);
      end
      bitPulse = 1'b1;
      @(negedge clk);
      bitPulse = 1'b0;
      for (int t = 0; t < 2; t++) begin
        if (seen[t] < 0 && p < mlen[t]) begin
          chk($sformatf("bit%0d_t%0d_dout", p, t), int'(dout_v[t]), int'(mbit[t][p]));
          chk($sformatf("bit%0d_t%0d_stuff", p, t), int'(sact_v[t]), int'(mstf[t][p]));
        end
      end
      look_done(p + 1);
      repeat (2) begin
        @(negedge clk);
        look_done(p + 1);
      end
      p++;
    end
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("t%0d_bits_at_done", t), seen[t], mlen[t]);
      chk($sformatf("t%0d_stuffcount", t), cap_s[t], mscnt[t]);
      chk($sformatf("t%0d_runlen", t), cap_r[t], mrun[t]);
      chk($sformatf("t%0d_lastbit", t), cap_l[t], mlast[t]);
      chk($sformatf("t%0d_done_single", t), extra[t], 0);
      chk($sformatf("t%0d_idle_busy", t), int'(busy_v[t]), 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("%s_t%0d_dout", tag, t), int'(dout_v[t]), 1);
      chk($sformatf("%s_t%0d_last", tag, t), int'(last_v[t]), 1);
      chk($sformatf("%s_t%0d_busy", tag, t), int'(busy_v[t]), 0);
      chk($sformatf("%s_t%0d_done", tag, t), int'(done_v[t]), 0);
      chk($sformatf("%s_t%0d_sact", tag, t), int'(sact_v[t]), 0);
      chk($sformatf("%s_t%0d_scnt", tag, t), int'(scnt_v[t]), 0);
      chk($sformatf("%s_t%0d_run", tag, t), int'(run_v[t]), 0);
    end
  endtask

  typedef struct {
    logic [10:0] id;
    logic        r;
    logic [3:0]  d;
    int len0, len1, sc0, sc1, run0, run1, last0, last1;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int abort_done;
    start = 0; abort = 0; bitPulse = 0; canId = '0; rtr = 0; msgSize = '0;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    resetN = 1'b1;
    @(negedge clk);

    tbl[0] = '{11'h000, 1'b0, 4'h0, 22, 22, 3, 3, 4, 4, 0, 0};
    tbl[1] = '{11'h7FF, 1'b1, 4'h8, 21, 21, 2, 2, 3, 3, 0, 0};
    tbl[2] = '{11'h7F8, 1'b0, 4'h0, 21, 22, 2, 3, 5, 1, 0, 1};
    tbl[3] = '{11'h555, 1'b0, 4'h5, 19, 19, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].id, tbl[i].r, tbl[i].d, 1'b0, 1'b0);
      chk($sformatf("vec%0d_len_t0", i), seen[0], tbl[i].len0);
      chk($sformatf("vec%0d_len_t1", i), seen[1], tbl[i].len1);
      chk($sformatf("vec%0d_scnt_t0", i), cap_s[0], tbl[i].sc0);
      chk($sformatf("vec%0d_scnt_t1", i), cap_s[1], tbl[i].sc1);
      chk($sformatf("vec%0d_run_t0", i), cap_r[0], tbl[i].run0);
      chk($sformatf("vec%0d_run_t1", i), cap_r[1], tbl[i].run1);
      chk($sformatf("vec%0d_last_t0", i), cap_l[0], tbl[i].last0);
      chk($sformatf("vec%0d_last_t1", i), cap_l[1], tbl[i].last1);
    end

    // Abort after the 7th bit time: stream so far is 00000 1 0
    canId = 11'h000; rtr = 1'b0; msgSize = 4'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) pulse_gap();
    chk("pre_abort_dout", int'(dout_v[1]), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_dout", int'(dout_v), 3);
    chk("abort_busy", int'(busy_v), 0);
    chk("abort_sact", int'(sact_v), 0);
    chk("abort_done", int'(done_v), 0);
    abort_done = 0;
    for (int k = 0; k < 4; k++) begin
      bitPulse = 1'b1;
      @(negedge clk);
      bitPulse = 1'b0;
      if (done_v != 2'b00) abort_done++;
      repeat (2) begin
        @(negedge clk);
        if (done_v != 2'b00) abort_done++;
      end
    end
    chk("abort_no_done", abort_done, 0);
    chk("abort_idle_dout", int'(dout_v), 3);

    // Fresh frame right after abort, with start coincident with a bitPulse
    run_frame(11'h0F0, 1'b1, 4'h3, 1'b1, 1'b0);
    // start while busy with changed fields must not disturb the frame
    run_frame(11'h3C1, 1'b0, 4'hA, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_frame(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of S_SEND
    canId = 11'h000; rtr = 1'b0; msgSize = 4'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) pulse_gap();
    chk("pre_reset_busy", int'(busy_v[1]), 1);
    chk("pre_reset_run", int'(run_v[1]), 3);
    #2 resetN = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    run_frame(11'h1AB, 1'b1, 4'hF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
